// File: rtl/pkt_merge_avlstrm_pkg.sv
// Shared types for the 2-to-1 Avalon-ST packet merge: FSM states and the
// stats register map used by the control-plane reader.
package pkt_merge_avlstrm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } merge_state_t;

  localparam logic [3:0] REG_MERGE_PKT0    = 4'h0;
  localparam logic [3:0] REG_MERGE_PKT1    = 4'h4;
  localparam logic [3:0] REG_MERGE_OUT_PKT = 4'h8;
  localparam logic [3:0] REG_MERGE_ERR     = 4'hC;

  function automatic merge_state_t lock_state(input logic sel);
    return sel ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/avl_stream_if.sv
// Avalon-ST packet stream bundle, ready latency 0.
interface avl_stream_if #(
  parameter int WIDTH   = 512,
  parameter int EMPTY_W = 6
);
  logic [WIDTH-1:0]   data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport rx (input data, valid, sop, eop, empty, output ready);
  modport tx (output data, valid, sop, eop, empty, input ready);
endinterface

// File: rtl/pkt_merge_avlstrm_reg_slice.sv
// avlstrm_reg_slice: 2-entry skid register; all outputs come straight from
// flops and input ready depends only on local state.
module avlstrm_reg_slice #(
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_pay_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [PW-1:0] out_pay_o
);
  logic          main_v_q, skid_v_q;
  logic [PW-1:0] main_q, skid_q;

  assign in_ready_o  = !skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_pay_o   = main_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (!main_v_q || out_ready_i) begin
      // input ready was low while the skid held data, so nothing is lost here
      if (skid_v_q) begin
        main_q   <= skid_q;
        main_v_q <= 1'b1;
        skid_v_q <= 1'b0;
      end else begin
        main_v_q <= in_valid_i;
        if (in_valid_i) main_q <= in_pay_i;
      end
    end else if (in_valid_i && !skid_v_q) begin
      skid_q   <= in_pay_i;
      skid_v_q <= 1'b1;
    end
  end
endmodule

// File: rtl/pkt_merge_avlstrm.sv
// 2-to-1 packet-atomic round-robin Avalon-ST merge with stats counters.
// Define PKT_MERGE_OUT_REG_EN to drive out from a 2-entry skid register.
module pkt_merge_avlstrm
  import pkt_merge_avlstrm_pkg::*;
#(
  parameter int WIDTH   = 512,
  parameter int EMPTY_W = 6
) (
  input  logic        Clk,
  input  logic        Rst_n,
  avl_stream_if.rx    in0,
  avl_stream_if.rx    in1,
  avl_stream_if.tx    out,
  output logic [31:0] stats_in_pkt0,
  output logic [31:0] stats_in_pkt1,
  output logic [31:0] stats_out_pkt,
  output logic [31:0] stats_proto_err
);
  localparam int PW = WIDTH + EMPTY_W + 2;

  merge_state_t state_q;
  logic         rr_last_q;
  logic [31:0]  pkt0_q, pkt1_q, out_pkt_q, err_q, err_d;
  logic         cand0, cand1, grant, gsel, drain0, drain1;
  logic         arb_valid, arb_ready, arb_eop, xfer, out_eop_xfer;
  logic [PW-1:0] pay0, pay1, arb_pay;

  assign cand0 = in0.valid && in0.sop;
  assign cand1 = in1.valid && in1.sop;
  assign pay0  = {in0.data, in0.sop, in0.eop, in0.empty};
  assign pay1  = {in1.data, in1.sop, in1.eop, in1.empty};

  always_comb begin
    grant = 1'b0;
    gsel  = 1'b0;
    case (state_q)
      IDLE: begin
        grant = cand0 || cand1;
        gsel  = (cand0 && cand1) ? ~rr_last_q : cand1;
      end
      LOCK0: grant = 1'b1;
      LOCK1: begin
        grant = 1'b1;
        gsel  = 1'b1;
      end
      default: ;
    endcase
    if (!Rst_n) grant = 1'b0;
  end

  // stray non-sop beats are only swallowed while nobody owns the output
  assign drain0 = Rst_n && (state_q == IDLE) && in0.valid && !in0.sop;
  assign drain1 = Rst_n && (state_q == IDLE) && in1.valid && !in1.sop;

  assign arb_valid = grant && (gsel ? in1.valid : in0.valid);
  assign arb_pay   = gsel ? pay1 : pay0;
  assign arb_eop   = gsel ? in1.eop : in0.eop;
  assign xfer      = arb_valid && arb_ready;

  assign in0.ready = (grant && !gsel) ? arb_ready : drain0;
  assign in1.ready = (grant &&  gsel) ? arb_ready : drain1;

`ifdef PKT_MERGE_OUT_REG_EN
  logic [PW-1:0] out_pay;

  avlstrm_reg_slice #(.PW(PW)) u_slice (
    .clk_i       (Clk),
    .rst_n_i     (Rst_n),
    .in_valid_i  (arb_valid),
    .in_ready_o  (arb_ready),
    .in_pay_i    (arb_pay),
    .out_valid_o (out.valid),
    .out_ready_i (out.ready),
    .out_pay_o   (out_pay)
  );
  assign {out.data, out.sop, out.eop, out.empty} = out_pay;
  assign out_eop_xfer = out.valid && out.ready && out.eop;
`else
  assign arb_ready    = out.ready;
  assign out.valid    = arb_valid;
  assign {out.data, out.sop, out.eop, out.empty} = arb_pay;
  assign out_eop_xfer = xfer && arb_eop;
`endif

  assign err_d = err_q + 32'(drain0) + 32'(drain1);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      pkt0_q    <= '0;
      pkt1_q    <= '0;
      out_pkt_q <= '0;
      err_q     <= '0;
    end else begin
      if (xfer) begin
        if (state_q == IDLE) rr_last_q <= gsel;
        if (arb_eop) begin
          state_q <= IDLE;
          if (gsel) pkt1_q <= pkt1_q + 32'd1;
          else      pkt0_q <= pkt0_q + 32'd1;
        end else begin
          state_q <= lock_state(gsel);
        end
      end
      if (out_eop_xfer) out_pkt_q <= out_pkt_q + 32'd1;
      err_q <= err_d;
    end
  end

  assign stats_in_pkt0   = pkt0_q;
  assign stats_in_pkt1   = pkt1_q;
  assign stats_out_pkt   = out_pkt_q;
  assign stats_proto_err = err_q;
endmodule

// File: tb/tb_pkt_merge_avlstrm.sv
// Bench for pkt_merge_avlstrm: queue-fed sources, a per-cycle ownership model
// of the merge rules, directed scenarios and a randomized traffic phase.
module tb_pkt_merge_avlstrm;
  localparam int W  = 512;
  localparam int EW = 6;

  typedef struct {
    logic          v;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [W-1:0]  data;
  } beat_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_p0, s_p1, s_out, s_err;

  avl_stream_if #(.WIDTH(W), .EMPTY_W(EW)) in0_if ();
  avl_stream_if #(.WIDTH(W), .EMPTY_W(EW)) in1_if ();
  avl_stream_if #(.WIDTH(W), .EMPTY_W(EW)) out_if ();

  pkt_merge_avlstrm #(.WIDTH(W), .EMPTY_W(EW)) dut (
    .Clk             (clk),
    .Rst_n           (rst_n),
    .in0             (in0_if),
    .in1             (in1_if),
    .out             (out_if),
    .stats_in_pkt0   (s_p0),
    .stats_in_pkt1   (s_p1),
    .stats_out_pkt   (s_out),
    .stats_proto_err (s_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  beat_t       q0[$], q1[$];
  beat_t       cur0, cur1, idle_b;
  logic        xf0 = 1'b0, xf1 = 1'b0;
  logic        rand_rdy = 1'b0;
  logic [W-1:0] olog[$];
  int          olog_cyc[$];

  // reference: which input owns the output, who won last, expected counters
  int          lock = -1;
  logic        last = 1'b1;
  logic [31:0] m_p0 = '0, m_p1 = '0, m_out = '0, m_err = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] d;
    for (int i = 0; i < W/32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic beat_t mk(input logic sop, input logic eop);
    beat_t b;
    b.v     = 1'b1;
    b.sop   = sop;
    b.eop   = eop;
    b.empty = EW'($urandom_range(0, 63));
    b.data  = rnd_data();
    return b;
  endfunction

  task automatic push(input int src, input beat_t b);
    if (src == 0) q0.push_back(b);
    else          q1.push_back(b);
  endtask

  task automatic push_pkt(input int src, input int len, output logic [W-1:0] first);
    beat_t b;
    first = '0;
    for (int i = 0; i < len; i++) begin
      b = mk(i == 0, i == len - 1);
      if (i == 0) first = b.data;
      push(src, b);
    end
  endtask

  task automatic apply();
    in0_if.valid = cur0.v;  in0_if.sop = cur0.sop;  in0_if.eop = cur0.eop;
    in0_if.empty = cur0.empty;  in0_if.data = cur0.data;
    in1_if.valid = cur1.v;  in1_if.sop = cur1.sop;  in1_if.eop = cur1.eop;
    in1_if.empty = cur1.empty;  in1_if.data = cur1.data;
  endtask

  task automatic flush();
    q0.delete();
    q1.delete();
    cur0 = idle_b;
    cur1 = idle_b;
    apply();
  endtask

  // sources hold each beat until it is accepted, then pop the next entry
  always @(posedge clk) begin
    cyc++;
    #1;
    if (xf0 || !cur0.v) begin
      if (q0.size() != 0) cur0 = q0.pop_front();
      else                cur0 = idle_b;
    end
    if (xf1 || !cur1.v) begin
      if (q1.size() != 0) cur1 = q1.pop_front();
      else                cur1 = idle_b;
    end
    if (rand_rdy) out_if.ready = ($urandom_range(0, 9) < 7);
    apply();
  end

  always @(negedge clk) begin : cmp
    logic v0, v1, c0, c1, ev, er0, er1, dr0, dr1, ordy, geop;
    int   g;
    v0   = in0_if.valid;
    v1   = in1_if.valid;
    c0   = v0 && in0_if.sop;
    c1   = v1 && in1_if.sop;
    ordy = out_if.ready;
    chk("stats_in_pkt0", W'(s_p0), W'(m_p0));
    chk("stats_in_pkt1", W'(s_p1), W'(m_p1));
    chk("stats_out_pkt", W'(s_out), W'(m_out));
    chk("stats_proto_err", W'(s_err), W'(m_err));
    g = -1; ev = 1'b0; er0 = 1'b0; er1 = 1'b0; dr0 = 1'b0; dr1 = 1'b0;
    if (rst_n) begin
      if (lock >= 0)      g = lock;
      else if (c0 && c1)  g = last ? 0 : 1;
      else if (c0)        g = 0;
      else if (c1)        g = 1;
      if (g == 0) begin ev = v0; er0 = ordy; end
      if (g == 1) begin ev = v1; er1 = ordy; end
      dr0 = (lock < 0) && (g != 0) && v0 && !in0_if.sop;
      dr1 = (lock < 0) && (g != 1) && v1 && !in1_if.sop;
      er0 = er0 | dr0;
      er1 = er1 | dr1;
    end
    chk("out_valid", W'(out_if.valid), W'(ev));
    chk("in0_ready", W'(in0_if.ready), W'(er0));
    chk("in1_ready", W'(in1_if.ready), W'(er1));
    if (ev) begin
      chk("out_data", out_if.data, (g == 1) ? in1_if.data : in0_if.data);
      chk("out_sop", W'(out_if.sop), W'((g == 1) ? in1_if.sop : in0_if.sop));
      chk("out_eop", W'(out_if.eop), W'((g == 1) ? in1_if.eop : in0_if.eop));
      chk("out_empty", W'(out_if.empty), W'((g == 1) ? in1_if.empty : in0_if.empty));
    end
    xf0 = v0 && in0_if.ready;
    xf1 = v1 && in1_if.ready;
    if (rst_n && out_if.valid && ordy) begin
      olog.push_back(out_if.data);
      olog_cyc.push_back(cyc);
    end
    if (!rst_n) begin
      lock = -1; last = 1'b1;
      m_p0 = '0; m_p1 = '0; m_out = '0; m_err = '0;
    end else begin
      if (ev && ordy) begin
        geop = (g == 1) ? in1_if.eop : in0_if.eop;
        if (lock < 0) last = (g == 1);
        if (geop) begin
          if (g == 1) m_p1 = m_p1 + 32'd1;
          else        m_p0 = m_p0 + 32'd1;
          m_out = m_out + 32'd1;
          lock  = -1;
        end else begin
          lock = g;
        end
      end
      m_err = m_err + 32'(dr0) + 32'(dr1);
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || cur0.v || cur1.v) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: sources still busy after %0d cycles (limit %0d)", n, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    flush();
    repeat (cycles) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [W-1:0] a0, a1, b0, b1;
    logic [W-1:0] ea[$];
    logic [31:0]  base0, base1;
    beat_t        b;
    int           n, len, src;

    idle_b.v = 1'b0; idle_b.sop = 1'b0; idle_b.eop = 1'b0;
    idle_b.empty = '0; idle_b.data = '0;
    cur0 = idle_b;
    cur1 = idle_b;
    out_if.ready = 1'b1;
    apply();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", W'(out_if.valid), '0);
    chk("rst_in0_ready", W'(in0_if.ready), '0);
    chk("rst_pkt0", W'(s_p0), '0);
    chk("rst_err", W'(s_err), '0);

    // single 3-beat packet on in0
    olog.delete(); olog_cyc.delete();
    push_pkt(0, 3, a0);
    wait_idle(200);
    chk("t1_beats", W'(olog.size()), W'(3));
    chk("t1_first", olog[0], a0);
    chk("t1_nogap", W'(olog_cyc[2] - olog_cyc[0]), W'(2));
    chk("t1_pkt0", W'(s_p0), W'(1));
    chk("t1_out_pkt", W'(s_out), W'(1));

    // simultaneous sops right after reset: in0 first, then in1, then in0, then in1
    do_reset(2);
    olog.delete();
    push_pkt(0, 2, a0); push_pkt(0, 2, a1);
    push_pkt(1, 2, b0); push_pkt(1, 2, b1);
    wait_idle(200);
    chk("t2_beats", W'(olog.size()), W'(8));
    chk("t2_first_in0", olog[0], a0);
    chk("t2_second_in1", olog[2], b0);
    chk("t2_third_in0", olog[4], a1);
    chk("t2_fourth_in1", olog[6], b1);
    chk("t2_pkt0", W'(s_p0), W'(2));
    chk("t2_pkt1", W'(s_p1), W'(2));

    // in0 bubbles mid-packet while in1 waits with a sop
    olog.delete(); ea.delete();
    b = mk(1'b1, 1'b0); ea.push_back(b.data); push(0, b);
    repeat (4) push(0, idle_b);
    b = mk(1'b0, 1'b0); ea.push_back(b.data); push(0, b);
    b = mk(1'b0, 1'b1); ea.push_back(b.data); push(0, b);
    b = mk(1'b1, 1'b1); b0 = b.data; push(1, b);
    wait_idle(200);
    chk("t3_beats", W'(olog.size()), W'(4));
    for (int k = 0; k < 3; k++) chk("t3_in0_beat", olog[k], ea[k]);
    chk("t3_in1_last", olog[3], b0);

    // alternating single-beat packets
    base0 = s_p0; base1 = s_p1;
    olog.delete(); ea.delete();
    for (int i = 0; i < 4; i++) begin
      b = mk(1'b1, 1'b1); push(0, b); ea.push_back(b.data);
      b = mk(1'b1, 1'b1); push(1, b); ea.push_back(b.data);
    end
    wait_idle(200);
    for (int k = 0; k < 8; k++) chk("t4_alternate", olog[k], ea[k]);
    chk("t4_pkt0_delta", W'(s_p0 - base0), W'(4));
    chk("t4_pkt1_delta", W'(s_p1 - base1), W'(4));

    // stray non-sop beat on in1
    olog.delete();
    b = mk(1'b0, 1'b1); push(1, b);
    wait_idle(200);
    chk("t5_proto_err", W'(s_err), W'(1));
    chk("t5_no_output", W'(olog.size()), '0);

    // reset in the middle of a 4-beat in0 packet
    olog.delete();
    push_pkt(0, 4, a0);
    n = 0;
    while (olog.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_beat_seen", W'(olog.size() != 0), W'(1));
    do_reset(1);
    chk("t6_out_valid", W'(out_if.valid), '0);
    chk("t6_pkt0", W'(s_p0), '0);
    chk("t6_out_pkt", W'(s_out), '0);
    chk("t6_err", W'(s_err), '0);
    olog.delete();
    push_pkt(1, 1, b0);
    wait_idle(200);
    chk("t6_in1_accepted", W'(s_p1), W'(1));
    chk("t6_in1_data", olog[0], b0);

    // randomized traffic with backpressure, bubbles and stray beats
    for (int p = 0; p < 150; p++) begin
      src = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) begin
        push(src, mk(1'b0, 1'($urandom_range(0, 1))));
      end else begin
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) begin
          push(src, mk(i == 0, i == len - 1));
          if (i < len - 1 && $urandom_range(0, 4) == 0)
            repeat ($urandom_range(1, 3)) push(src, idle_b);
        end
      end
      if ($urandom_range(0, 3) == 0) push(src, idle_b);
    end
    rand_rdy = 1'b1;
    wait_idle(20000);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_if.ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
